// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU for the MIPS core.
//   Single-cycle R-type operations are purely combinational. An iterative
//   multiply/divide unit produces one bit per cycle. Its result goes to the
//   architectural HI/LO registers.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   op             R-type function code
//   a, b           operands rs and rt (b carries a zero-extended shamt for shifts)
//   issue          the instruction in EX is valid this cycle
//   abort          pipeline flush: cancels an in-flight mul/div
//   result         combinational result
//   zero           asserted when result is zero
//   overflow       signed overflow, asserted only for ADD and SUB
//   stall          EX cannot complete this cycle (HI/LO access while busy)
//   busy           mul/div iteration in progress
//   done           one-cycle pulse when HI/LO receive a mul/div result
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             issue,
  input  logic             abort,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             stall,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] OP_SLL  = 6'b000000, OP_SRL  = 6'b000010, OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SLLV = 6'b000100, OP_SRLV = 6'b000110, OP_SRAV = 6'b000111;
  localparam logic [5:0] OP_MFHI = 6'b010000, OP_MTHI = 6'b010001;
  localparam logic [5:0] OP_MFLO = 6'b010010, OP_MTLO = 6'b010011;
  localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV  = 6'b011010, OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADD  = 6'b100000, OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010, OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100, OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110, OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010, OP_SLTU = 6'b101011;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] pl_q, pl_d;       // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand magnitude / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;         // negate product or quotient
  logic             neg_rem_q, neg_rem_d; // remainder follows the dividend sign
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SLLV: result = a << shamt;
      OP_SRL, OP_SRLV: result = a >> shamt;
      OP_SRA, OP_SRAV: result = $signed(a) >>> shamt;
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // ---------------- HI/LO access control ----------------
  logic is_md, is_hilo, accept, start;

  assign is_md   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_hilo = is_md || (op == OP_MFHI) || (op == OP_MFLO) ||
                   (op == OP_MTHI) || (op == OP_MTLO);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign stall   = issue && busy && is_hilo;
  assign accept  = issue && !busy;
  assign start   = accept && is_md;

  // Operand sign handling at start: the iteration works on magnitudes.
  logic             signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // ---------------- one iteration step ----------------
  // Multiply: add the multiplicand when the multiplier LSB is set, then shift
  // {carry, acc, pl} right; product bits fill pl from the top.
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  assign mul_add = pl_q[0] ? opd_q : '0;
  assign mul_sum = {1'b0, acc_q} + {1'b0, mul_add};

  // Restoring divide: bring in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so it always fits in WIDTH bits.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_sh  = {acc_q, pl_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opd_q});
  assign div_rem = div_ge ? (div_sh[WIDTH-1:0] - opd_q) : div_sh[WIDTH-1:0];

  logic [WIDTH-1:0] step_acc, step_pl;
  assign step_acc = is_div_q ? div_rem : mul_sum[WIDTH:1];
  assign step_pl  = is_div_q ? {pl_q[WIDTH-2:0], div_ge} : {mul_sum[0], pl_q[WIDTH-1:1]};

  // Sign fix-up applied to the last step's output as it is written to HI/LO.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem, fin_hi, fin_lo;
  assign prod     = {step_acc, step_pl};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot     = div0_q ? '1 : (neg_q ? -step_pl : step_pl);
  assign rem      = neg_rem_q ? -step_acc : step_acc;  // a/0 leaves |a|, restored to a
  assign fin_hi   = is_div_q ? rem  : prod_fix[2*WIDTH-1:WIDTH];
  assign fin_lo   = is_div_q ? quot : prod_fix[WIDTH-1:0];

  // ---------------- sequencing ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    pl_d      = pl_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          pl_d  = step_pl;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d = S_DONE;
            hi_d    = fin_hi;
            lo_d    = fin_lo;
          end
        end
      end
      default: begin  // IDLE and DONE both accept new work
        state_d = S_IDLE;
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          acc_d     = '0;
          opd_d     = div_op ? mag_b : mag_a;
          pl_d      = div_op ? mag_a : mag_b;
          is_div_d  = div_op;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = div_op && (b == '0);
        end else if (accept && op == OP_MTHI) begin
          hi_d = a;
        end else if (accept && op == OP_MTLO) begin
          lo_d = a;
        end
      end
    endcase
  end

  // NOTE: the operand and partial registers are reset along with HI/LO, so a
  // reset mid-operation leaves no stale state that could leak into a later run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      pl_q      <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      pl_q      <= pl_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: self-checking bench for alu_muldiv (WIDTH=32).
//   Table vectors for the single-cycle ops and the mul/div corner cases, hand
//   sequences for stall/abort/reset timing, then random stimulus against a
//   behavioural model built on 64-bit integer arithmetic.
module tb_alu_muldiv;

  localparam logic [5:0] SLL  = 6'b000000, SRL  = 6'b000010, SRA  = 6'b000011;
  localparam logic [5:0] SLLV = 6'b000100, SRLV = 6'b000110, SRAV = 6'b000111;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001;
  localparam logic [5:0] MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
  localparam logic [5:0] DIV  = 6'b011010, DIVU  = 6'b011011;
  localparam logic [5:0] ADD  = 6'b100000, ADDU = 6'b100001;
  localparam logic [5:0] SUB  = 6'b100010, SUBU = 6'b100011;
  localparam logic [5:0] AND_ = 6'b100100, OR_  = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110, NOR_ = 6'b100111;
  localparam logic [5:0] SLT  = 6'b101010, SLTU = 6'b101011;

  localparam longint MAX_S = 64'sh7FFF_FFFF;
  localparam longint MIN_S = -64'sh8000_0000;

  logic        clk, rst_n, issue, abort;
  logic [5:0]  op;
  logic [31:0] a, b, result;
  logic        zero, overflow, stall, busy, done;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] hi_m = 0, lo_m = 0;  // model copy of HI/LO

  alu_muldiv #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b), .issue(issue), .abort(abort),
    .result(result), .zero(zero), .overflow(overflow), .stall(stall),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural models ----------------
  function automatic void model_alu(input logic [5:0] o, input logic [31:0] x, y,
                                    output logic [31:0] r, output logic ov);
    longint sx, sy, t;
    int sh;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[4:0]);
    r  = 0;
    ov = 0;
    case (o)
      ADD:  begin t = sx + sy; r = x + y; ov = (t > MAX_S) || (t < MIN_S); end
      ADDU: r = x + y;
      SUB:  begin t = sx - sy; r = x - y; ov = (t > MAX_S) || (t < MIN_S); end
      SUBU: r = x - y;
      AND_: r = x & y;
      OR_:  r = x | y;
      XOR_: r = x ^ y;
      NOR_: r = ~(x | y);
      SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      SLTU: r = (x < y) ? 32'd1 : 32'd0;
      SLL, SLLV: r = x << sh;
      SRL, SRLV: r = x >> sh;
      SRA, SRAV: begin t = sx >>> sh; r = t[31:0]; end
      MFHI: r = hi_m;
      MFLO: r = lo_m;
      default: r = 0;
    endcase
  endfunction

  function automatic void md_model(input logic [5:0] o, input logic [31:0] x, y,
                                   output logic [31:0] hi, lo);
    longint sx, sy, p, q, rm;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    hi = 0;
    lo = 0;
    case (o)
      MULT:  begin p = sx * sy; hi = p[63:32]; lo = p[31:0]; end
      MULTU: begin up = {32'b0, x} * {32'b0, y}; hi = up[63:32]; lo = up[31:0]; end
      DIV: begin
        if (y == 0) begin lo = '1; hi = x; end
        else begin q = sx / sy; rm = sx % sy; lo = q[31:0]; hi = rm[31:0]; end
      end
      DIVU: begin
        if (y == 0) begin lo = '1; hi = x; end
        else begin lo = x / y; hi = x % y; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issue a mul/div, count busy cycles, then check done and HI/LO in the done cycle.
  task automatic run_md(input logic [5:0] o, input logic [31:0] x, y,
                        input logic [31:0] exp_hi, exp_lo, input string tag);
    int n;
    op = o; a = x; b = y; issue = 1'b1;
    #1 check({tag, " start stall"}, {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    issue = 1'b0; op = 6'd0; a = 0; b = 0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy cycles"}, 32'(n), 32'd32);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    op = MFHI; issue = 1'b1;
    #1 check({tag, " HI"}, result, exp_hi);
    op = MFLO;
    #1 check({tag, " LO"}, result, exp_lo);
    issue = 1'b0; op = 6'd0;
    hi_m = exp_hi;
    lo_m = exp_lo;
    @(posedge clk); #1;
    check({tag, " done pulse width"}, {31'b0, done}, 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, res;
    logic        z, ov;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, hi, lo;
  } md_t;

  vec_t vecs[18];
  md_t  mds[8];

  initial begin
    logic [31:0] er, eh, el;
    logic        eov;
    int          n;
    bit          saw_done;

    vecs[0]  = '{ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{ADDU, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0};
    vecs[2]  = '{SUB,  32'h5,         32'h5,         32'h0,         1'b1, 1'b0};
    vecs[3]  = '{SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0};
    vecs[4]  = '{SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
    vecs[5]  = '{SRA,  32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1'b0};
    vecs[6]  = '{SRLV, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 1'b0};
    vecs[7]  = '{SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[8]  = '{SUBU, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{NOR_, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{6'h3F, 32'h5,        32'h6,         32'h0,         1'b1, 1'b0};
    vecs[11] = '{SLLV, 32'h1,         32'h3F,        32'h8000_0000, 1'b0, 1'b0};
    vecs[12] = '{ADD,  32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1};
    vecs[13] = '{XOR_, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0};
    vecs[14] = '{SRAV, 32'h7FFF_FFF0, 32'h4,         32'h07FF_FFFF, 1'b0, 1'b0};
    vecs[15] = '{SRL,  32'h8000_0000, 32'd31,        32'h1,         1'b0, 1'b0};
    vecs[16] = '{SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0};
    vecs[17] = '{SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};

    mds[0] = '{DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    mds[1] = '{DIVU,  32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF};
    mds[2] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    mds[3] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    mds[4] = '{DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
    mds[5] = '{DIV,   32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
    mds[6] = '{DIVU,  32'hFFFF_FFFF, 32'h2,         32'h1,         32'h7FFF_FFFF};
    mds[7] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

    // ---- reset state ----
    rst_n = 1'b0; issue = 1'b0; abort = 1'b0; op = MFHI; a = 0; b = 0;
    #3;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset HI", result, 32'd0);
    op = MFLO;
    #1 check("reset LO", result, 32'd0);
    check("reset zero flag", {31'b0, zero}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- single-cycle table ----
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d zero", i), {31'b0, zero}, {31'b0, vecs[i].z});
      check($sformatf("vec%0d overflow", i), {31'b0, overflow}, {31'b0, vecs[i].ov});
    end
    @(posedge clk); #1;

    // ---- MULT -3*7 with MFHI stalled in busy cycle 5, released in cycle 33 ----
    op = MULT; a = 32'hFFFF_FFFD; b = 32'd7; issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        op = MFHI; issue = 1'b1;
        #1 check("MFHI stall in busy cycle 5", {31'b0, stall}, 32'd1);
      end
      @(posedge clk); #1;
    end
    check("mult busy cycles", 32'(n), 32'd32);
    check("mult done", {31'b0, done}, 32'd1);
    check("MFHI stall after run", {31'b0, stall}, 32'd0);
    check("mult HI via MFHI", result, 32'hFFFF_FFFF);
    op = MFLO;
    #1 check("mult LO via MFLO", result, 32'hFFFF_FFEB);
    issue = 1'b0; op = 6'd0;
    @(posedge clk); #1;
    check("mult done one cycle", {31'b0, done}, 32'd0);

    // ---- mul/div corner table ----
    for (int i = 0; i < 8; i++)
      run_md(mds[i].op, mds[i].a, mds[i].b, mds[i].hi, mds[i].lo, $sformatf("md%0d", i));

    // ---- MTHI/MTLO, then MULTU aborted at busy cycle 10 ----
    op = MTHI; a = 32'h1234; issue = 1'b1;
    #1 check("MTHI result", result, 32'd0);
    @(posedge clk); #1;
    op = MTLO; a = 32'h5678;
    @(posedge clk); #1;
    op = MULTU; a = 32'd100; b = 32'd100;
    @(posedge clk); #1;
    issue = 1'b0; op = 6'd0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 10) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    check("abort busy cycles", 32'(n), 32'd10);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("abort done never pulses", {31'b0, saw_done}, 32'd0);
    op = MFHI; issue = 1'b1;
    #1 check("abort HI kept", result, 32'h1234);
    op = MFLO;
    #1 check("abort LO kept", result, 32'h5678);
    issue = 1'b0;
    hi_m = 32'h1234; lo_m = 32'h5678;

    // ---- MULTU issued while busy is stalled and ignored ----
    op = MULTU; a = 32'd100; b = 32'd100; issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0; op = 6'd0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        op = MULTU; a = 32'd5; b = 32'd5; issue = 1'b1;
        #1 check("MULTU while busy stall", {31'b0, stall}, 32'd1);
      end
      if (n == 4) begin issue = 1'b0; op = 6'd0; end
      @(posedge clk); #1;
    end
    check("busy-issue busy cycles", 32'(n), 32'd32);
    op = MFHI; issue = 1'b1;
    #1 check("busy-issue HI", result, 32'd0);
    op = MFLO;
    #1 check("busy-issue LO", result, 32'd10000);
    issue = 1'b0;

    // ---- reset during DIVU busy cycle 17 ----
    op = MTHI; a = 32'hAAAA; issue = 1'b1;
    @(posedge clk); #1;
    op = DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    issue = 1'b0; op = 6'd0;
    for (int c = 1; c < 17; c++) begin
      @(posedge clk); #1;
    end
    check("divu busy at cycle 17", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1 check("reset mid-run busy", {31'b0, busy}, 32'd0);
    check("reset mid-run done", {31'b0, done}, 32'd0);
    op = MFHI;
    #1 check("reset mid-run HI", result, 32'd0);
    op = MFLO;
    #1 check("reset mid-run LO", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hi_m = 0; lo_m = 0;
    run_md(MULT, 32'd2, 32'd3, 32'd0, 32'd6, "mult after reset");

    // ---- random mul/div against the model ----
    for (int i = 0; i < 24; i++) begin
      logic [5:0]  o;
      logic [31:0] x, y;
      case ($urandom_range(0, 3))
        0: o = MULT;
        1: o = MULTU;
        2: o = DIV;
        default: o = DIVU;
      endcase
      x = pick();
      y = pick();
      md_model(o, x, y, eh, el);
      run_md(o, x, y, eh, el, $sformatf("rand md%0d op=%b a=%h b=%h", i, o, x, y));
    end

    // ---- random single-cycle ops against the model ----
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      op = 6'($urandom_range(0, 63)); a = pick(); b = pick(); issue = 1'b0;
      model_alu(op, a, b, er, eov);
      #1;
      check($sformatf("rand op=%b a=%h b=%h result", op, a, b), result, er);
      check($sformatf("rand op=%b zero", op), {31'b0, zero}, {31'b0, (er == 0)});
      check($sformatf("rand op=%b overflow", op), {31'b0, overflow}, {31'b0, eov});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
